// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook-time countdown.
// Digits are 4-bit BCD; the controller FSM states are enumerated here.
package microwave_pkg;

   localparam int DIGIT_W          = 4;
   localparam int BCD_MAX_ONES     = 9;
   localparam int BCD_MAX_TENS_SEC = 5;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READY   = 3'd1,
      ST_RUNNING = 3'd2,
      ST_PAUSED  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam digit_t MAX_ONES_D     = digit_t'(BCD_MAX_ONES);
   localparam digit_t MAX_TENS_SEC_D = digit_t'(BCD_MAX_TENS_SEC);

   function automatic logic digit_ok(input digit_t d, input digit_t max);
      return d <= max;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter: wraps 0 -> MAX and raises borrow_out
// combinationally so digits can be chained from least to most significant.
module bcd_digit_down
   import microwave_pkg::*;
#(
   parameter int MAX = 9
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   clr,
   input  logic   load,
   input  digit_t load_val,
   input  logic   en,
   input  logic   borrow_in,
   output digit_t value,
   output logic   borrow_out
);

   localparam digit_t MAX_D = digit_t'(MAX);

   assign borrow_out = borrow_in && (value == '0);

   always_ff @(posedge clk) begin
      if (reset || clr)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (en && borrow_in)
         value <= (value == '0) ? MAX_D : value - digit_t'(1);
   end

endmodule

// File: rtl/microwave_countdown.sv
// MM:SS cook-time countdown: control FSM and tick prescaler driving a chain
// of four BCD down-counting digits, plus registered status pulses.
module microwave_countdown
   import microwave_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [3:0] load_min_t,
   input  logic [3:0] load_min_o,
   input  logic [3:0] load_sec_t,
   input  logic [3:0] load_sec_o,
   input  logic       start,
   input  logic       stop_clr,
   input  logic       door_closed,
   output logic [3:0] min_t,
   output logic [3:0] min_o,
   output logic [3:0] sec_t,
   output logic [3:0] sec_o,
   output logic       running,
   output logic       magnetron_on,
   output logic       done,
   output logic       load_err
);

   localparam int          PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

   state_t        state, state_nxt;
   logic [PW-1:0] presc;
   logic          load_valid, load_zero, time_zero, time_one;
   logic          start_ev, load_ev, load_ok, load_bad, tick_ev, dec, last, digit_clr;
   logic          b_so, b_st, b_mo, b_mt;

   assign load_valid = digit_ok(load_min_t, MAX_ONES_D) && digit_ok(load_min_o, MAX_ONES_D) &&
                       digit_ok(load_sec_t, MAX_TENS_SEC_D) && digit_ok(load_sec_o, MAX_ONES_D);
   assign load_zero  = {load_min_t, load_min_o, load_sec_t, load_sec_o} == 16'h0000;
   assign time_zero  = {min_t, min_o, sec_t, sec_o} == 16'h0000;
   assign time_one   = {min_t, min_o, sec_t, sec_o} == 16'h0001;

   // Event qualification in priority order: stop_clr > door open > start > load > tick
   assign start_ev  = !stop_clr && start && door_closed &&
                      (state == ST_READY || state == ST_PAUSED);
   assign load_ev   = !stop_clr && !start_ev && load && (state != ST_RUNNING);
   assign load_ok   = load_ev && load_valid;
   assign load_bad  = load_ev && !load_valid;
   assign tick_ev   = !stop_clr && door_closed && tick && (state == ST_RUNNING);
   assign dec       = tick_ev && (presc == PRESC_LAST) && !time_zero;
   assign last      = dec && time_one;
   assign digit_clr = stop_clr && (state != ST_RUNNING);

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (stop_clr)
         state_nxt = (state == ST_RUNNING) ? ST_PAUSED : ST_IDLE;
      else if (state == ST_RUNNING && !door_closed)
         state_nxt = ST_PAUSED;
      else if (start_ev)
         state_nxt = ST_RUNNING;
      else if (load_ok)
         state_nxt = load_zero ? ST_IDLE : ST_READY;
      else if (last)
         state_nxt = ST_DONE;
   end

   always_comb begin
      running = (state == ST_RUNNING);
   end

   // Resuming from PAUSED keeps the prescaler so the partial second carries over
   always_ff @(posedge clk) begin
      if (reset) begin
         presc        <= '0;
         done         <= 1'b0;
         load_err     <= 1'b0;
         magnetron_on <= 1'b0;
      end else begin
         if (digit_clr || load_ok || (start_ev && state == ST_READY))
            presc <= '0;
         else if (tick_ev)
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
         done         <= last;
         load_err     <= load_bad;
         magnetron_on <= (state == ST_RUNNING) && door_closed;
      end
   end

   bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_sec_o (
      .clk(clk), .reset(reset), .clr(digit_clr), .load(load_ok), .load_val(load_sec_o),
      .en(dec), .borrow_in(1'b1), .value(sec_o), .borrow_out(b_so)
   );

   bcd_digit_down #(.MAX(BCD_MAX_TENS_SEC)) u_sec_t (
      .clk(clk), .reset(reset), .clr(digit_clr), .load(load_ok), .load_val(load_sec_t),
      .en(dec), .borrow_in(b_so), .value(sec_t), .borrow_out(b_st)
   );

   bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_min_o (
      .clk(clk), .reset(reset), .clr(digit_clr), .load(load_ok), .load_val(load_min_o),
      .en(dec), .borrow_in(b_st), .value(min_o), .borrow_out(b_mo)
   );

   // Never borrows past 00:00 because dec is gated by time_zero
   bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_min_t (
      .clk(clk), .reset(reset), .clr(digit_clr), .load(load_ok), .load_val(load_min_t),
      .en(dec), .borrow_in(b_mo), .value(min_t), .borrow_out(b_mt)
   );

   logic unused_borrow;
   assign unused_borrow = b_mt;

endmodule

// File: tb/tb_microwave_countdown.sv
// Bench for microwave_countdown: directed scenarios then random traffic, all
// checked against a seconds-based behavioural model of the controller.
module tb_microwave_countdown;

   localparam int TPS = 2;
   localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1, tick = 1'b0, load = 1'b0, start = 1'b0, stop_clr = 1'b0;
   logic       door_closed = 1'b1;
   logic [3:0] load_min_t = '0, load_min_o = '0, load_sec_t = '0, load_sec_o = '0;
   logic [3:0] min_t, min_o, sec_t, sec_o;
   logic       running, magnetron_on, done, load_err;

   int n_asserts = 0;
   int n_fail    = 0;

   int m_st = M_IDLE, m_secs = 0, m_presc = 0;
   bit m_done = 0, m_err = 0, m_mag = 0;

   always #5 clk = ~clk;

   microwave_countdown #(.TICKS_PER_SEC(TPS)) dut (
      .clk(clk), .reset(reset), .tick(tick), .load(load),
      .load_min_t(load_min_t), .load_min_o(load_min_o),
      .load_sec_t(load_sec_t), .load_sec_o(load_sec_o),
      .start(start), .stop_clr(stop_clr), .door_closed(door_closed),
      .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
      .running(running), .magnetron_on(magnetron_on), .done(done), .load_err(load_err)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] cur_time();
      return {min_t, min_o, sec_t, sec_o};
   endfunction

   // Model works in whole seconds; BCD only appears when forming expectations
   task automatic model_step();
      bit nd, ne, nmag;
      int lt;
      if (reset) begin
         m_st = M_IDLE; m_secs = 0; m_presc = 0; m_done = 0; m_err = 0; m_mag = 0;
         return;
      end
      nd = 0; ne = 0;
      nmag = (m_st == M_RUN) && door_closed;
      if (stop_clr) begin
         if (m_st == M_RUN) m_st = M_PAUSE;
         else begin m_st = M_IDLE; m_secs = 0; m_presc = 0; end
      end else if (m_st == M_RUN && !door_closed) begin
         m_st = M_PAUSE;
      end else if (start && door_closed && (m_st == M_READY || m_st == M_PAUSE)) begin
         if (m_st == M_READY) m_presc = 0;
         m_st = M_RUN;
      end else if (load && m_st != M_RUN) begin
         if (load_min_t > 9 || load_min_o > 9 || load_sec_t > 5 || load_sec_o > 9) begin
            ne = 1;
         end else begin
            lt = (int'(load_min_t) * 10 + int'(load_min_o)) * 60 +
                 int'(load_sec_t) * 10 + int'(load_sec_o);
            m_secs = lt; m_presc = 0;
            m_st = (lt != 0) ? M_READY : M_IDLE;
         end
      end else if (tick && m_st == M_RUN) begin
         if (m_presc == TPS - 1) begin
            m_presc = 0;
            if (m_secs > 0) begin
               m_secs--;
               if (m_secs == 0) begin m_st = M_DONE; nd = 1; end
            end
         end else begin
            m_presc++;
         end
      end
      m_done = nd; m_err = ne; m_mag = nmag;
   endtask

   task automatic check_all(input string tag);
      int mins, s;
      logic [15:0] exp_t;
      mins  = m_secs / 60;
      s     = m_secs % 60;
      exp_t = {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
      chk({tag, ":time"}, cur_time(), exp_t);
      chk({tag, ":running"}, 16'(running), 16'(m_st == M_RUN));
      chk({tag, ":magnetron"}, 16'(magnetron_on), 16'(m_mag));
      chk({tag, ":done"}, 16'(done), 16'(m_done));
      chk({tag, ":load_err"}, 16'(load_err), 16'(m_err));
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
      reset = 0; tick = 0; load = 0; start = 0; stop_clr = 0;
   endtask

   task automatic do_load(input int mt, input int mo, input int st, input int so);
      load_min_t = 4'(mt); load_min_o = 4'(mo); load_sec_t = 4'(st); load_sec_o = 4'(so);
      load = 1;
      cyc("load");
   endtask

   task automatic do_start();
      start = 1;
      cyc("start");
   endtask

   task automatic do_stop();
      stop_clr = 1;
      cyc("stop");
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1;
         cyc("tick");
         cyc("gap");
      end
   endtask

   initial begin
      int done_cnt;

      reset = 1;
      cyc("reset");
      reset = 1;
      cyc("reset2");
      chk("reset_time", cur_time(), 16'h0000);
      chk("reset_running", 16'(running), 16'h0000);

      // 00:03 counts down every second tick and finishes with one done pulse
      do_load(0, 0, 0, 3);
      chk("t1_loaded", cur_time(), 16'h0003);
      do_start();
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick = 1;
         cyc("t1_tick");
         done_cnt += int'(done);
         cyc("t1_gap");
         done_cnt += int'(done);
         if (i == 1) chk("t1_0002", cur_time(), 16'h0002);
         if (i == 3) chk("t1_0001", cur_time(), 16'h0001);
      end
      chk("t1_final", cur_time(), 16'h0000);
      chk("t1_done_count", 16'(done_cnt), 16'h0001);
      start = 1;
      cyc("t1_start_in_done");
      chk("t1_done_no_restart", 16'(running), 16'h0000);
      do_stop();

      // Borrow across digits
      do_load(0, 1, 0, 0);
      do_start();
      do_ticks(2);
      chk("t2_0059", cur_time(), 16'h0059);
      do_stop();
      do_stop();
      do_load(1, 0, 0, 0);
      do_start();
      do_ticks(2);
      chk("t3_0959", cur_time(), 16'h0959);
      do_stop();
      do_stop();

      // Rejected loads keep the current time
      do_load(0, 5, 3, 0);
      do_load(0, 1, 6, 0);
      chk("t4_err_pulse", 16'(load_err), 16'h0001);
      chk("t4_time_kept", cur_time(), 16'h0530);
      cyc("t4_after");
      chk("t4_err_once", 16'(load_err), 16'h0000);
      do_load(10, 0, 0, 0);
      do_stop();

      // Zero load stays idle and start does nothing
      do_load(0, 0, 0, 0);
      do_start();
      cyc("t5_idle");
      chk("t5_not_running", 16'(running), 16'h0000);

      // Door opening pauses; partial second resumes after start
      do_load(0, 0, 1, 0);
      do_start();
      tick = 1;
      cyc("t6_tick");
      door_closed = 0;
      cyc("t6_door_open");
      chk("t6_paused", 16'(running), 16'h0000);
      chk("t6_mag_off", 16'(magnetron_on), 16'h0000);
      cyc("t6_door_wait");
      door_closed = 1;
      cyc("t6_door_close");
      chk("t6_no_autoresume", 16'(running), 16'h0000);
      do_start();
      tick = 1;
      cyc("t6_resume_tick");
      chk("t6_0009", cur_time(), 16'h0009);

      // stop_clr pauses, then clears
      do_stop();
      chk("t7_paused", 16'(running), 16'h0000);
      chk("t7_held", cur_time(), 16'h0009);
      do_stop();
      chk("t7_cleared", cur_time(), 16'h0000);

      // Reset beats a completing tick
      do_load(0, 0, 0, 1);
      do_start();
      tick = 1;
      cyc("t8_tick");
      reset = 1; tick = 1;
      cyc("t8_reset");
      chk("t8_done_low", 16'(done), 16'h0000);
      chk("t8_time", cur_time(), 16'h0000);
      cyc("t8_after");

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         reset    = ($urandom_range(0, 199) == 0);
         tick     = ($urandom_range(0, 2) == 0);
         load     = ($urandom_range(0, 24) == 0);
         start    = ($urandom_range(0, 5) == 0);
         stop_clr = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) door_closed = ~door_closed;
         if ($urandom_range(0, 4) == 0) begin
            load_min_t = 4'($urandom_range(0, 15));
            load_min_o = 4'($urandom_range(0, 15));
            load_sec_t = 4'($urandom_range(0, 15));
            load_sec_o = 4'($urandom_range(0, 15));
         end else begin
            load_min_t = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
            load_min_o = 4'($urandom_range(0, 1));
            load_sec_t = 4'($urandom_range(0, 1));
            load_sec_o = 4'($urandom_range(0, 9));
         end
         cyc("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
